// File: rtl/k12a_spi_ctrl.sv
// rtl/k12a_spi_ctrl.sv - FIFO-buffered SPI master on the k12a I/O bus
// Register file, TX/RX FIFOs and a two-state shift engine sharing one SCK/MOSI.
module k12a_spi_ctrl #(
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                cpu_clock,
  input  logic                reset_n,
  input  logic                sel,
  input  logic                io_load,
  input  logic                io_store,
  input  logic [1:0]          io_addr,
  inout  wire  [7:0]          data_bus,
  output logic                spi_sck,
  output logic                spi_mosi,
  output logic [CHANNELS-1:0] spi_cs_n,
  input  logic [CHANNELS-1:0] spi_miso
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;
  state_t state_q, state_d;

  logic rd, wr;
  assign rd = sel & io_load;
  assign wr = sel & io_store;

  logic       cs_act_q, lsb_first_q, cpol_q, cpha_q;
  logic [2:0] ch_q;
  logic [7:0] div_q;
  logic       tx_ovf_q, rx_ovf_q;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic        tx_empty, tx_full, rx_empty, rx_full;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);

  logic busy, load, eng_push, sample, shift;
  logic cpu_push, cpu_pop, tx_push_ok, rx_push_ok;
  assign cpu_push   = wr && (io_addr == 2'd0);
  assign cpu_pop    = rd && (io_addr == 2'd0) && !rx_empty;
  assign tx_push_ok = cpu_push && (!tx_full || load);
  assign rx_push_ok = eng_push && (!rx_full || cpu_pop);

  logic [7:0] div_cnt_q, tx_sh_q, rx_sh_q;
  logic [3:0] half_q;
  logic       sck_q, mosi_q;
  logic       tick, last, leading, miso_sel;
  logic [7:0] tx_head, rx_shifted, rx_byte;

  assign tx_head    = tx_mem[tx_rp_q[AW-1:0]];
  assign tick       = (div_cnt_q == div_q);
  assign last       = tick && (half_q == 4'd15);
  assign leading    = ~half_q[0];
  assign rx_shifted = lsb_first_q ? {miso_sel, rx_sh_q[7:1]} : {rx_sh_q[6:0], miso_sel};
  // With cpha=1 the final sample lands on the closing toggle itself.
  assign rx_byte    = sample ? rx_shifted : rx_sh_q;

  always_comb begin
    spi_cs_n = '1;
    miso_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_q == 3'(i)) begin
        spi_cs_n[i] = ~cs_act_q;
        miso_sel    = spi_miso[i];
      end
    end
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!tx_empty) state_d = S_XFER;
      S_XFER:  if (last && tx_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    load     = 1'b0;
    eng_push = 1'b0;
    sample   = 1'b0;
    shift    = 1'b0;
    case (state_q)
      S_IDLE: load = !tx_empty;
      S_XFER: begin
        busy = 1'b1;
        if (tick) begin
          sample   = leading ^ cpha_q;
          // cpha=1 already presents bit 0 from the load, so its first leading toggle holds.
          shift    = !last && (cpha_q ? (leading && (half_q != 4'd0)) : !leading);
          eng_push = last;
          load     = last && !tx_empty;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      tx_sh_q   <= 8'h00;
      rx_sh_q   <= 8'h00;
      div_cnt_q <= 8'h00;
      half_q    <= 4'd0;
    end else begin
      if (state_q == S_IDLE) sck_q <= cpol_q;
      else if (tick)         sck_q <= ~sck_q;
      if (state_q == S_XFER) begin
        if (tick) begin
          div_cnt_q <= 8'h00;
          half_q    <= half_q + 4'd1;
        end else begin
          div_cnt_q <= div_cnt_q + 8'd1;
        end
      end
      if (load) begin
        tx_sh_q   <= tx_head;
        mosi_q    <= lsb_first_q ? tx_head[0] : tx_head[7];
        div_cnt_q <= 8'h00;
        half_q    <= 4'd0;
      end else if (shift) begin
        tx_sh_q <= lsb_first_q ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
        mosi_q  <= lsb_first_q ? tx_sh_q[1] : tx_sh_q[6];
      end
      if (sample) rx_sh_q <= rx_shifted;
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (tx_push_ok) tx_mem[tx_wp_q[AW-1:0]] <= data_bus;
    if (rx_push_ok) rx_mem[rx_wp_q[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp_q     <= '0;
      tx_rp_q     <= '0;
      rx_wp_q     <= '0;
      rx_rp_q     <= '0;
      tx_ovf_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      cs_act_q    <= 1'b0;
      ch_q        <= 3'd0;
      lsb_first_q <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      div_q       <= 8'h00;
    end else begin
      if (tx_push_ok) tx_wp_q <= tx_wp_q + PTR_ONE;
      if (load)       tx_rp_q <= tx_rp_q + PTR_ONE;
      if (rx_push_ok) rx_wp_q <= rx_wp_q + PTR_ONE;
      if (cpu_pop)    rx_rp_q <= rx_rp_q + PTR_ONE;
      if (wr && (io_addr == 2'd1)) begin
        if (data_bus[2]) tx_ovf_q <= 1'b0;
        if (data_bus[1]) rx_ovf_q <= 1'b0;
      end
      if (cpu_push && !tx_push_ok) tx_ovf_q <= 1'b1;
      if (eng_push && !rx_push_ok) rx_ovf_q <= 1'b1;
      if (wr && !busy && (io_addr == 2'd2)) begin
        cs_act_q    <= data_bus[7];
        ch_q        <= data_bus[6:4];
        lsb_first_q <= data_bus[2];
        cpol_q      <= data_bus[1];
        cpha_q      <= data_bus[0];
      end
      if (wr && !busy && (io_addr == 2'd3)) div_q <= data_bus;
    end
  end

  logic [7:0] rd_data;
  always_comb begin
    rd_data = 8'h00;
    case (io_addr)
      2'd0: rd_data = rx_empty ? 8'h00 : rx_mem[rx_rp_q[AW-1:0]];
      2'd1: rd_data = {busy, tx_full, tx_empty, rx_full, rx_empty, tx_ovf_q, rx_ovf_q, 1'b0};
      2'd2: rd_data = {cs_act_q, ch_q, 1'b0, lsb_first_q, cpol_q, cpha_q};
      2'd3: rd_data = div_q;
      default: rd_data = 8'h00;
    endcase
  end

  assign data_bus = rd ? rd_data : 8'hzz;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_k12a_spi_ctrl.sv
// tb/tb_k12a_spi_ctrl.sv - directed bench for k12a_spi_ctrl with RX scoreboard
module tb_k12a_spi_ctrl;
  localparam int CH = 2;

  logic          cpu_clock = 1'b0;
  logic          reset_n   = 1'b0;
  logic          sel = 1'b0, io_load = 1'b0, io_store = 1'b0;
  logic [1:0]    io_addr = 2'd0;
  wire  [7:0]    data_bus;
  logic [7:0]    drv_data = 8'h00;
  logic          drv_en = 1'b0;
  logic          spi_sck, spi_mosi;
  logic [CH-1:0] spi_cs_n;
  wire  [CH-1:0] spi_miso;

  logic          loopback = 1'b0, slave_en = 1'b0, slave_bit = 1'b0;
  logic [CH-1:0] miso_fix = '0;
  logic [7:0]    slave_byte = 8'h00;
  int            slave_idx = 0;

  assign data_bus    = drv_en ? drv_data : 8'hzz;
  assign spi_miso[0] = loopback ? spi_mosi : (slave_en ? slave_bit : miso_fix[0]);
  assign spi_miso[1] = miso_fix[1];

  k12a_spi_ctrl #(.CHANNELS(CH), .FIFO_DEPTH(4)) dut (
    .cpu_clock(cpu_clock), .reset_n(reset_n), .sel(sel), .io_load(io_load),
    .io_store(io_store), .io_addr(io_addr), .data_bus(data_bus), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso)
  );

  always #5 cpu_clock = ~cpu_clock;

  int n_cmp = 0, n_err = 0;
  logic [7:0] exp_q[$];

  // Bus-side observers: SCK toggle timing, MOSI at the slave's sample edge.
  int   cyc = 0;
  always @(posedge cpu_clock) cyc++;
  logic sck_last = 1'b0, mon_cpol = 1'b0, mon_cpha = 1'b0;
  int   tog_n = 0, first_cyc = 0, last_cyc = 0, min_iv = 0, max_iv = 0, iv = 0;
  logic mosi_bits[$];
  int   byte_end[$];

  always @(negedge cpu_clock) begin
    if (spi_sck !== sck_last) begin
      if (tog_n == 0) first_cyc = cyc;
      else begin
        iv = cyc - last_cyc;
        if (tog_n == 1 || iv < min_iv) min_iv = iv;
        if (tog_n == 1 || iv > max_iv) max_iv = iv;
      end
      last_cyc = cyc;
      tog_n++;
      if (tog_n % 16 == 0) byte_end.push_back(cyc);
      if ((spi_sck != mon_cpol) ^ mon_cpha) mosi_bits.push_back(spi_mosi);
      sck_last = spi_sck;
    end
  end

  // Slave driving on the leading (falling, cpol=1) edge, LSB first.
  always @(negedge spi_sck) begin
    if (slave_en) begin
      slave_bit = slave_byte[slave_idx[2:0]];
      slave_idx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic mon_clear(input logic cpol, input logic cpha);
    tog_n = 0;
    mosi_bits.delete();
    byte_end.delete();
    sck_last = spi_sck;
    mon_cpol = cpol;
    mon_cpha = cpha;
  endtask

  function automatic logic [7:0] packed_mosi(input logic lsb);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < 8 && i < mosi_bits.size(); i++)
      if (lsb) b[i] = mosi_bits[i];
      else     b[7-i] = mosi_bits[i];
    return b;
  endfunction

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge cpu_clock);
    sel = 1'b1; io_store = 1'b1; io_addr = a; drv_data = d; drv_en = 1'b1;
    @(posedge cpu_clock);
    #1;
    sel = 1'b0; io_store = 1'b0; drv_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge cpu_clock);
    sel = 1'b1; io_load = 1'b1; io_addr = a;
    #1 d = data_bus;
    @(posedge cpu_clock);
    #1;
    sel = 1'b0; io_load = 1'b0;
  endtask

  task automatic rd_data_chk(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    rd(2'd0, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check(tag, d, e);
  endtask

  task automatic wait_idle(input int budget);
    logic [7:0] s;
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      rd(2'd1, s);
      if (!s[7] && s[5]) done = 1'b1;
    end
    check("idle_wait", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    repeat (3) @(posedge cpu_clock);
    #1;
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_cs", spi_cs_n, 2'b11);
    @(negedge cpu_clock) reset_n = 1'b1;
    rd(2'd1, d); check("rst_status", d, 8'h28);
    rd(2'd2, d); check("rst_config", d, 8'h00);
    rd(2'd3, d); check("rst_div", d, 8'h00);

    // Reset mid-transfer
    wr(2'd3, 8'd2);
    wr(2'd2, 8'h80);
    check("cs_ch0", spi_cs_n, 2'b10);
    wr(2'd0, 8'hA5);
    repeat (20) @(posedge cpu_clock);
    rd(2'd1, d); check("mid_busy", d[7], 1);
    @(negedge cpu_clock);
    #2 reset_n = 1'b0;
    #1;
    check("abort_sck", spi_sck, 0);
    check("abort_cs", spi_cs_n, 2'b11);
    @(negedge cpu_clock) reset_n = 1'b1;
    rd(2'd1, d); check("abort_status", d, 8'h28);

    // Mode 0, DIV=0, loopback
    loopback = 1'b1;
    wr(2'd3, 8'd0);
    wr(2'd2, 8'h80);
    repeat (2) @(posedge cpu_clock);
    mon_clear(1'b0, 1'b0);
    wr(2'd0, 8'hA5); exp_q.push_back(8'hA5);
    rd(2'd1, d); check("start_pending", d, 8'h08);
    rd(2'd1, d); check("start_busy", d, 8'hA8);
    wait_idle(40);
    check("m0_toggles", tog_n, 16);
    check("m0_span", last_cyc - first_cyc, 15);
    check("m0_min_half", min_iv, 1);
    check("m0_max_half", max_iv, 1);
    check("m0_mosi", packed_mosi(1'b0), 8'hA5);
    rd_data_chk("m0_rx");
    rd(2'd1, d); check("m0_status", d, 8'h28);

    // Mode 3, LSB first, DIV=1
    loopback = 1'b0;
    slave_byte = 8'h3C; slave_idx = 0; slave_en = 1'b1;
    wr(2'd3, 8'd1);
    wr(2'd2, 8'h87);
    repeat (2) @(posedge cpu_clock);
    #1 check("m3_idle_high", spi_sck, 1);
    mon_clear(1'b1, 1'b1);
    wr(2'd0, 8'h96); exp_q.push_back(8'h3C);
    wait_idle(60);
    check("m3_toggles", tog_n, 16);
    check("m3_min_half", min_iv, 2);
    check("m3_max_half", max_iv, 2);
    check("m3_mosi", packed_mosi(1'b1), 8'h96);
    check("m3_end_sck", spi_sck, 1);
    rd_data_chk("m3_rx");
    slave_en = 1'b0;

    // FIFO full and overflow, DIV=7
    loopback = 1'b1;
    wr(2'd3, 8'd7);
    wr(2'd2, 8'h80);
    repeat (2) @(posedge cpu_clock);
    mon_clear(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      wr(2'd0, bytes[i]);
      if (i < 4) exp_q.push_back(bytes[i]);
    end
    rd(2'd1, d); check("ovf_tx_status", d, 8'hCC);
    wait_idle(800);
    check("ovf_toggles", tog_n, 80);
    check("ovf_min_half", min_iv, 8);
    check("ovf_max_half", max_iv, 8);
    check("ovf_bytes", byte_end.size(), 5);
    for (int i = 1; i < byte_end.size(); i++)
      check("ovf_b2b_gap", byte_end[i] - byte_end[i-1], 128);
    rd(2'd1, d); check("ovf_status", d, 8'h36);
    wr(2'd1, 8'h06);
    rd(2'd1, d); check("ovf_cleared", d, 8'h30);
    for (int i = 0; i < 4; i++) rd_data_chk("ovf_rx");
    rd(2'd0, d); check("rx_empty_read", d, 8'h00);
    rd(2'd1, d); check("ovf_final_status", d, 8'h28);

    // Config lockout while busy
    wr(2'd3, 8'd3);
    wr(2'd2, 8'h80);
    wr(2'd0, 8'h5A); exp_q.push_back(8'h5A);
    repeat (2) @(posedge cpu_clock);
    wr(2'd2, 8'h91);
    wr(2'd3, 8'd9);
    rd(2'd2, d); check("lock_config", d, 8'h80);
    rd(2'd3, d); check("lock_div", d, 8'd3);
    wait_idle(100);
    rd_data_chk("lock_rx");

    // Channel 1 selected, then out-of-range channel
    loopback = 1'b0;
    miso_fix = 2'b10;
    wr(2'd2, 8'h98);
    rd(2'd2, d); check("cfg_reserved", d, 8'h90);
    check("cs_ch1", spi_cs_n, 2'b01);
    wr(2'd0, 8'h00); exp_q.push_back(8'hFF);
    wait_idle(100);
    rd_data_chk("ch1_rx");
    wr(2'd2, 8'hD0);
    miso_fix = 2'b11;
    check("cs_ch5", spi_cs_n, 2'b11);
    wr(2'd0, 8'hFF); exp_q.push_back(8'h00);
    wait_idle(100);
    rd_data_chk("ch5_rx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
